// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO-fed, LSB-first serialiser paced by rising edges of baud_clk.
// Latency: a baud_clk rise moves tx 3 clk_in cycles later; a pushed byte is poppable the next cycle.
// Backpressure: tx_ready is low while the FIFO is full; with no ticks, bytes simply stay queued.
`timescale 1ns/1ps

// Small synchronous FIFO with occupancy count; the caller guards push-when-full and pop-when-empty.
// Latency: a write is visible at the head from the following cycle (no pass-through).
// Backpressure: none internally; the caller derives ready from count.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_in,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Storage write; contents need no reset because count gates every read.
    always_ff @(posedge clk_in) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; simultaneous push and pop keep count.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign pop_dat = mem[rd_ptr];
endmodule

module uart_tx_buffered #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                          clk_in,
    input  logic                          reset,
    input  logic                          baud_clk,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 baud_s1;
    logic                 baud_s2;
    logic                 baud_prev;
    logic                 tick;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_nxt;
    logic [DATA_BITS-1:0] head_dat;
    logic [BW-1:0]        bit_cnt;
    logic [BW-1:0]        bit_cnt_nxt;
    logic                 par;
    logic                 par_nxt;
    logic                 tx_nxt;
    logic                 push;
    logic                 pop;
    logic                 fifo_empty;

    // Two-flop synchroniser plus registered rise detect; everything resets high so a
    // baud_clk already high at reset release is not mistaken for a fresh edge.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            baud_s1   <= 1'b1;
            baud_s2   <= 1'b1;
            baud_prev <= 1'b1;
            tick      <= 1'b0;
        end else begin
            baud_s1   <= baud_clk;
            baud_s2   <= baud_s1;
            baud_prev <= baud_s2;
            tick      <= baud_s2 & ~baud_prev;
        end
    end

    // Ready looks only at the current occupancy, so a full FIFO refuses even when popping.
    assign tx_ready   = (fifo_count != CW'(FIFO_DEPTH));
    assign push       = tx_valid & tx_ready;
    assign fifo_empty = (fifo_count == '0);
    assign busy       = (state != IDLE);

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in   (clk_in),
        .reset    (reset),
        .push     (push),
        .push_dat (tx_data),
        .pop      (pop),
        .pop_dat  (head_dat),
        .count    (fifo_count)
    );

    // State and serialiser datapath registers; reset aborts any frame and parks the line high.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state   <= IDLE;
            tx      <= 1'b1;
            shreg   <= '0;
            bit_cnt <= '0;
            par     <= 1'b0;
        end else begin
            state   <= state_nxt;
            tx      <= tx_nxt;
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt_nxt;
            par     <= par_nxt;
        end
    end

    // Next-state logic: everything holds between ticks; STOP reloads directly for back-to-back frames.
    always_comb begin
        state_nxt   = state;
        tx_nxt      = tx;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        par_nxt     = par;
        pop         = 1'b0;
        if (tick) begin
            case (state)
                IDLE, STOP: begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        shreg_nxt = head_dat;
                        par_nxt   = (^head_dat) ^ (PARITY_ODD != 0);
                        tx_nxt    = 1'b0;
                        state_nxt = START;
                    end else begin
                        tx_nxt    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                START: begin
                    tx_nxt      = shreg[0];
                    shreg_nxt   = shreg >> 1;
                    bit_cnt_nxt = BW'(1);
                    state_nxt   = DATA;
                end
                DATA: begin
                    if (bit_cnt < BW'(DATA_BITS)) begin
                        tx_nxt      = shreg[0];
                        shreg_nxt   = shreg >> 1;
                        bit_cnt_nxt = bit_cnt + BW'(1);
                    end else if (PARITY_EN != 0) begin
                        tx_nxt    = par;
                        state_nxt = PARITY;
                    end else begin
                        tx_nxt    = 1'b1;
                        state_nxt = STOP;
                    end
                end
                PARITY: begin
                    tx_nxt    = 1'b1;
                    state_nxt = STOP;
                end
                default: begin
                    tx_nxt    = 1'b1;
                    state_nxt = IDLE;
                end
            endcase
        end
    end
endmodule
